// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard unit for a classic five-stage pipeline. It has four parts:
//   * Operand forwarding for the execute stage, and for the decode-stage
//     branch comparator.
//   * Load-use and branch-operand stall detection.
//   * A small FSM that stretches data-memory accesses by MEM_LAT cycles.
//   * Saturating statistics counters for stall and flush cycles.
//
// Handshake: there is no valid/ready pair here. memAccessM acts as a level
// request that the memory stage holds while its instruction sits in M.
// memBusy is the "not ready" answer. The access completes in the first cycle
// in which memAccessM=1 and memBusy=0. Once the wait ends, the FSM does not
// re-arm on that completing cycle.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   rsD, rtD                      decode-stage source register indices
//   rsE, rtE                      execute-stage source register indices
//   writeRegE/M/W                 destination index in E/M/W
//   regWriteE/M/W                 register-write enable in E/M/W
//   memToRegE, memToRegM          a load is present in E / M
//   branchD, PCSrcD               branch in decode / branch taken
//   memAccessM                    load or store present in the memory stage
//   clrStats                      synchronous clear of the statistics counters
//   stallF/D/E/M                  hold the stage register
//   flushD, flushE                turn the stage register into a bubble
//   forwardAE, forwardBE          00 reg file, 01 writeback, 10 memory
//   forwardAD, forwardBD          branch comparator takes the M-stage ALU result
//   memBusy                       data-memory wait in progress
//   stallCount, flushCount        saturating event counters
//   dbgMemWait, dbgMemCnt         memory FSM state and down-counter (debug)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 2,   // legal range 0..15
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rsD,
  input  logic [ADDR_W-1:0] rtD,
  input  logic [ADDR_W-1:0] rsE,
  input  logic [ADDR_W-1:0] rtE,
  input  logic [ADDR_W-1:0] writeRegE,
  input  logic [ADDR_W-1:0] writeRegM,
  input  logic [ADDR_W-1:0] writeRegW,
  input  logic              regWriteE,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic              memToRegE,
  input  logic              memToRegM,
  input  logic              branchD,
  input  logic              PCSrcD,
  input  logic              memAccessM,
  input  logic              clrStats,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              memBusy,
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  flushCount,
  output logic              dbgMemWait,
  output logic [3:0]        dbgMemCnt
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic       LAT_EN   = (MEM_LAT > 0);
  localparam logic [3:0] LAT_LOAD = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             w_mem_busy_raw;
  logic             w_mem_busy;

  logic             w_lw_stall;
  logic             w_branch_stall;
  logic             w_hazard_stall;
  logic             w_stall_fd;
  logic             w_flush_d;
  logic             w_flush_e;

  logic             w_m_match_rse;
  logic             w_m_match_rte;
  logic             w_w_match_rse;
  logic             w_w_match_rte;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // A forwarding source is valid only if the stage writes a register, the
  // destination is not the hardwired zero register, and the indices agree.
  function automatic logic fwd_match(input logic              we,
                                     input logic [ADDR_W-1:0] dst,
                                     input logic [ADDR_W-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    w_m_match_rse = fwd_match(regWriteM, writeRegM, rsE);
    w_m_match_rte = fwd_match(regWriteM, writeRegM, rtE);
    w_w_match_rse = fwd_match(regWriteW, writeRegW, rsE);
    w_w_match_rte = fwd_match(regWriteW, writeRegW, rtE);
  end

  // The memory stage holds the younger result, so it takes priority.
  always_comb begin
    forwardAE = 2'b00;
    if (w_m_match_rse)      forwardAE = 2'b10;
    else if (w_w_match_rse) forwardAE = 2'b01;

    forwardBE = 2'b00;
    if (w_m_match_rte)      forwardBE = 2'b10;
    else if (w_w_match_rte) forwardBE = 2'b01;
  end

  // The branch comparator can only take the M-stage ALU result. Anything
  // younger is covered by branchStall.
  assign forwardAD = fwd_match(regWriteM, writeRegM, rsD);
  assign forwardBD = fwd_match(regWriteM, writeRegM, rtD);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_lw_stall = memToRegE && ((rtE == rsD) || (rtE == rtD));

  // Two cases stall a decode-stage branch:
  //   * Its operands are still being computed in E.
  //   * Its operands are being loaded in M, where the load data is not yet
  //     forwardable.
  assign w_branch_stall = branchD && (
                            (regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
                            (memToRegM && (writeRegM != '0) &&
                             ((writeRegM == rsD) || (writeRegM == rtD))));

  assign w_hazard_stall = w_lw_stall || w_branch_stall;

  // ---------------------------------------------------------------------------
  // Memory-latency FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // memBusy is raised in the IDLE cycle in which the access is seen. It stays
  // raised for MEM_LAT-1 WAIT cycles, which gives MEM_LAT busy cycles in
  // total. The WAIT cycle with cnt=0 is the completion cycle. It always
  // returns to IDLE, so a held memAccessM is not counted twice.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mem_busy_raw = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (memAccessM && LAT_EN) begin
          w_state_nxt    = S_WAIT;
          w_cnt_nxt      = LAT_LOAD;
          w_mem_busy_raw = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt      = r_cnt - 4'd1;
          w_mem_busy_raw = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // The IDLE entry term depends only on memAccessM. Without the reset
  // qualifier, a held request would keep memBusy high during reset. With it,
  // reset kills any wait immediately.
  assign w_mem_busy = w_mem_busy_raw && rst;

  assign dbgMemWait = (r_state == S_WAIT);
  assign dbgMemCnt  = r_cnt;

  // ---------------------------------------------------------------------------
  // Stall / flush outputs
  // ---------------------------------------------------------------------------
  assign w_stall_fd = w_mem_busy || w_hazard_stall;

  // While memory is busy, E holds as well. Inserting a bubble into E then
  // would destroy the held instruction, so flushE is suppressed.
  assign w_flush_e  = w_hazard_stall && !w_mem_busy;

  // A taken branch that is itself stalled must not flush its own fetch slot.
  assign w_flush_d  = PCSrcD && !w_stall_fd;

  assign stallF  = w_stall_fd;
  assign stallD  = w_stall_fd;
  assign stallE  = w_mem_busy;
  assign stallM  = w_mem_busy;
  assign flushD  = w_flush_d;
  assign flushE  = w_flush_e;
  assign memBusy = w_mem_busy;

  // ---------------------------------------------------------------------------
  // Statistics counters (saturating, clear wins over increment)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clrStats) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_fd && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((w_flush_d || w_flush_e) && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. The main instance uses MEM_LAT=3 and
// CNT_W=4. A second instance with MEM_LAT=0 shares all inputs and shows that
// the zero-latency build never reports memBusy.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic              regWriteE, regWriteM, regWriteW;
  logic              memToRegE, memToRegM, branchD, PCSrcD, memAccessM, clrStats;

  logic              stallF, stallD, stallE, stallM, flushD, flushE;
  logic [1:0]        forwardAE, forwardBE;
  logic              forwardAD, forwardBD, memBusy;
  logic [CNT_W-1:0]  stallCount, flushCount;
  logic              dbgMemWait;
  logic [3:0]        dbgMemCnt;

  logic              z_stallF, z_stallD, z_stallE, z_stallM, z_flushD, z_flushE;
  logic [1:0]        z_forwardAE, z_forwardBE;
  logic              z_forwardAD, z_forwardBD, z_memBusy;
  logic [CNT_W-1:0]  z_stallCount, z_flushCount;
  logic              z_dbgMemWait;
  logic [3:0]        z_dbgMemCnt;

  hazard_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(3), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .PCSrcD(PCSrcD), .memAccessM(memAccessM), .clrStats(clrStats),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .memBusy(memBusy), .stallCount(stallCount), .flushCount(flushCount),
    .dbgMemWait(dbgMemWait), .dbgMemCnt(dbgMemCnt)
  );

  hazard_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .PCSrcD(PCSrcD), .memAccessM(memAccessM), .clrStats(clrStats),
    .stallF(z_stallF), .stallD(z_stallD), .stallE(z_stallE), .stallM(z_stallM),
    .flushD(z_flushD), .flushE(z_flushE),
    .forwardAE(z_forwardAE), .forwardBE(z_forwardBE),
    .forwardAD(z_forwardAD), .forwardBD(z_forwardBD),
    .memBusy(z_memBusy), .stallCount(z_stallCount), .flushCount(z_flushCount),
    .dbgMemWait(z_dbgMemWait), .dbgMemCnt(z_dbgMemCnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check tasks
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CNT_W-1:0] obs,
                      input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeRegE = '0; writeRegM = '0; writeRegW = '0;
    regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    memToRegE = 1'b0; memToRegM = 1'b0;
    branchD = 1'b0; PCSrcD = 1'b0; memAccessM = 1'b0; clrStats = 1'b0;
  endtask

  // Leaves the caller 1 ns after a rising edge, safely between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst = 1'b0;
    #3;
    // Reset state, with a memory request present during reset.
    memAccessM = 1'b1;
    #1;
    chkc("rst_stallCount", stallCount, 4'd0);
    chkc("rst_flushCount", flushCount, 4'd0);
    chk1("rst_memBusy", memBusy, 1'b0);
    chk1("rst_dbgWait", dbgMemWait, 1'b0);
    chk1("rst_stallE", stallE, 1'b0);
    memAccessM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Forwarding priority: M beats W.
    regWriteM = 1'b1; writeRegM = 5'd8; regWriteW = 1'b1; writeRegW = 5'd8; rsE = 5'd8;
    #1;
    chk2("fwdAE_mem_prio", forwardAE, 2'b10);
    chk2("fwdBE_none", forwardBE, 2'b00);
    writeRegM = 5'd0;
    #1;
    chk2("fwdAE_wb", forwardAE, 2'b01);
    rtE = 5'd8;
    #1;
    chk2("fwdBE_wb", forwardBE, 2'b01);
    regWriteW = 1'b0;
    #1;
    chk2("fwdAE_wb_disabled", forwardAE, 2'b00);
    // Decode-stage forwarding: only an M-stage match, and never register 0.
    writeRegM = 5'd12; rsD = 5'd12; rtD = 5'd3;
    #1;
    chk1("fwdAD_match", forwardAD, 1'b1);
    chk1("fwdBD_nomatch", forwardBD, 1'b0);
    writeRegM = 5'd0; rsD = 5'd0;
    #1;
    chk1("fwdAD_zero_reg", forwardAD, 1'b0);
    idle_inputs();
    tick();

    // Load-use stall: one cycle of stall and bubble.
    memToRegE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    chk1("lu_stallF", stallF, 1'b1);
    chk1("lu_stallD", stallD, 1'b1);
    chk1("lu_flushE", flushE, 1'b1);
    chk1("lu_stallE", stallE, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk1("lu_stallF_after", stallF, 1'b0);
    chkc("lu_stallCount", stallCount, 4'd1);
    chkc("lu_flushCount", flushCount, 4'd1);

    // Taken branch without a stall.
    branchD = 1'b1; PCSrcD = 1'b1;
    #1;
    chk1("br_flushD", flushD, 1'b1);
    chk1("br_flushE", flushE, 1'b0);
    tick();
    idle_inputs();
    #1;
    chkc("br_flushCount", flushCount, 4'd2);
    chkc("br_stallCount", stallCount, 4'd1);

    // Taken branch whose operand is still in E.
    branchD = 1'b1; PCSrcD = 1'b1; regWriteE = 1'b1; writeRegE = 5'd7; rsD = 5'd7;
    #1;
    chk1("brs_flushD", flushD, 1'b0);
    chk1("brs_flushE", flushE, 1'b1);
    chk1("brs_stallF", stallF, 1'b1);
    tick();
    idle_inputs();
    #1;
    chkc("brs_stallCount", stallCount, 4'd2);
    chkc("brs_flushCount", flushCount, 4'd3);

    // Branch operand loaded in M; writeRegM=0 never stalls.
    branchD = 1'b1; memToRegM = 1'b1; writeRegM = 5'd9; rtD = 5'd9;
    #1;
    chk1("brm_stallD", stallD, 1'b1);
    writeRegM = 5'd0; rtD = 5'd0;
    #1;
    chk1("brm_zero_stallD", stallD, 1'b0);
    tick();
    idle_inputs();
    #1;
    chkc("brm_stallCount", stallCount, 4'd2);

    // Memory wait, MEM_LAT=3, request held high.
    memAccessM = 1'b1;
    #1;
    chk1("mw0_memBusy", memBusy, 1'b1);
    chk1("mw0_stallE", stallE, 1'b1);
    chk1("mw0_stallM", stallM, 1'b1);
    chk1("mw0_flushE", flushE, 1'b0);
    chk1("lat0_memBusy", z_memBusy, 1'b0);
    chk1("lat0_stallE", z_stallE, 1'b0);
    tick();
    chk1("mw1_memBusy", memBusy, 1'b1);
    chk1("mw1_dbgWait", dbgMemWait, 1'b1);
    // A load-use hazard while memory is busy must not insert a bubble.
    memToRegE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    chk1("mw1_flushE_lu", flushE, 1'b0);
    chk1("mw1_stallF_lu", stallF, 1'b1);
    memToRegE = 1'b0; rtE = '0; rsD = '0;
    tick();
    chk1("mw2_memBusy", memBusy, 1'b1);
    chk1("mw2_stallM", stallM, 1'b1);
    tick();
    chk1("mw3_memBusy", memBusy, 1'b0);
    chk1("mw3_stallE", stallE, 1'b0);
    tick();
    chk1("mw4_rearm_memBusy", memBusy, 1'b1);
    memAccessM = 1'b0;
    #1;
    chk1("mw4_drop_memBusy", memBusy, 1'b0);
    tick();
    chkc("mw_stallCount", stallCount, 4'd5);
    chkc("mw_flushCount", flushCount, 4'd3);
    chk1("mw_dbgWait_idle", dbgMemWait, 1'b0);

    // Saturation: 20 load-use cycles, then clear while stalled.
    memToRegE = 1'b1; rtE = 5'd4; rtD = 5'd4;
    for (int i = 0; i < 20; i++) tick();
    chkc("sat_stallCount", stallCount, 4'd15);
    chkc("sat_flushCount", flushCount, 4'd15);
    clrStats = 1'b1;
    tick();
    clrStats = 1'b0;
    chkc("clr_stallCount", stallCount, 4'd0);
    chkc("clr_flushCount", flushCount, 4'd0);
    tick();
    chkc("post_clr_stallCount", stallCount, 4'd1);
    idle_inputs();
    tick();
    chkc("post_clr_hold", stallCount, 4'd1);

    // Reset asserted during cycle 2 of a wait.
    memAccessM = 1'b1;
    tick();
    tick();
    chk1("rw_memBusy_before", memBusy, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rw_memBusy_async", memBusy, 1'b0);
    chk1("rw_dbgWait", dbgMemWait, 1'b0);
    chkc("rw_stallCount", stallCount, 4'd0);
    memAccessM = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk1("rw_release_memBusy", memBusy, 1'b0);
    tick();
    chk1("rw_after_memBusy", memBusy, 1'b0);
    chk1("rw_after_dbgWait", dbgMemWait, 1'b0);
    chk1("lat0_final_memBusy", z_memBusy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
